demux_stream_dispatch: RTL and testbench

//  Packet-aware dispatcher for the 1-to-4 demux path: takes one valid/ready input stream and

---
 rtl/demux_pkg.sv | 21 ++
 rtl/chan_onehot_4.sv | 22 ++
 rtl/demux_stream_dispatch.sv | 110 +++++++++++
 tb/tb_demux_stream_dispatch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 packet dispatcher.
// Channel widths, FSM state encoding and the dispatch-mode encoding.
package demux_pkg;

    localparam int CHAN_W = 2;
    localparam int N_CHAN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_e;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Round-robin successor; the 2-bit add wraps 3 -> 0 naturally.
    function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] c);
        return c + 2'd1;
    endfunction

endpackage

// File: rtl/chan_onehot_4.sv
// Decodes the locked channel into a one-hot valid vector (gated by slot occupancy)
// and selects that channel's ready.
module chan_onehot_4
    import demux_pkg::*;
(
    input  logic [CHAN_W-1:0] chan_i,
    input  logic              slot_full_i,
    input  logic [N_CHAN-1:0] out_ready_i,
    output logic [N_CHAN-1:0] onehot_o,
    output logic              sel_ready_o
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        onehot_o    = '0;
        sel_ready_o = out_ready_i[chan_i];
        if (slot_full_i) begin
            onehot_o[chan_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_stream_dispatch.sv
// Packet-aware 1-to-4 dispatcher: locks a channel per packet (addressed or round-robin)
// and presents each beat from a single registered slot with full-throughput handshaking.
module demux_stream_dispatch
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHAN_W-1:0] in_dest,
    input  logic              in_last,
    input  logic              mode,
    output logic [N_CHAN-1:0] out_valid,
    input  logic [N_CHAN-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [CHAN_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                slot_full_q, slot_full_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;

    logic                sel_ready;
    logic                accept;
    logic                leave;
    logic [CHAN_W-1:0]   beat_chan;

    // The slot always holds a beat of the packet on chan_q: a new first beat can only be
    // accepted when the slot is empty or draining in the same cycle.
    chan_onehot_4 u_chan_onehot (
        .chan_i      (chan_q),
        .slot_full_i (slot_full_q),
        .out_ready_i (out_ready),
        .onehot_o    (out_valid),
        .sel_ready_o (sel_ready)
    );

    assign leave    = slot_full_q && sel_ready;
    assign in_ready = !slot_full_q || sel_ready;
    assign accept   = in_valid && in_ready;

    // Channel for the beat being offered: chosen fresh in IDLE, locked while OPEN.
    always_comb begin
        beat_chan = chan_q;
        if (state_q == IDLE) begin
            case (mode)
                MODE_ADDR: beat_chan = in_dest;
                MODE_RR:   beat_chan = rr_ptr_q;
                default:   beat_chan = in_dest;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        rr_ptr_d    = rr_ptr_q;
        slot_full_d = slot_full_q;
        data_d      = data_q;
        last_d      = last_q;

        if (leave) begin
            slot_full_d = 1'b0;
        end

        if (accept) begin
            slot_full_d = 1'b1;
            data_d      = in_data;
            last_d      = in_last;
            chan_d      = beat_chan;
            if (in_last) begin
                state_d  = IDLE;
                rr_ptr_d = next_chan(beat_chan);
            end else begin
                state_d  = OPEN;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            rr_ptr_q    <= '0;
            slot_full_q <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            rr_ptr_q    <= rr_ptr_d;
            slot_full_q <= slot_full_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end

    assign out_data = data_q;
    assign out_last = last_q;
    assign busy     = (state_q == OPEN);

endmodule

// File: tb/tb_demux_stream_dispatch.sv
// Directed bench for demux_stream_dispatch: linear stimulus with hand-computed expectations.
module tb_demux_stream_dispatch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       in_last;
    logic       mode;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    demux_stream_dispatch #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dst,
                         input logic l, input logic m);
        in_valid = v;
        in_data  = d;
        in_dest  = dst;
        in_last  = l;
        mode     = m;
    endtask

    task automatic expect_beat(input string tag, input logic [3:0] v,
                               input logic [7:0] d, input logic l);
        check({tag, ".valid"}, 8'(out_valid), 8'(v));
        check({tag, ".data"},  out_data,      d);
        check({tag, ".last"},  8'(out_last),  8'(l));
    endtask

    initial begin
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        out_ready = 4'b0000;

        // Reset state
        #3;
        check("rst.valid",    8'(out_valid), 8'h00);
        check("rst.data",     out_data,      8'h00);
        check("rst.last",     8'(out_last),  8'h00);
        check("rst.busy",     8'(busy),      8'h00);
        check("rst.in_ready", 8'(in_ready),  8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Addressed packet to channel 2, three beats, all ready
        out_ready = 4'b1111;
        drive(1'b1, 8'hA1, 2'd2, 1'b0, 1'b0);
        tick();
        expect_beat("t1.A", 4'b0100, 8'hA1, 1'b0);
        check("t1.A.busy", 8'(busy), 8'h01);
        drive(1'b1, 8'hB2, 2'd2, 1'b0, 1'b0);
        tick();
        expect_beat("t1.B", 4'b0100, 8'hB2, 1'b0);
        check("t1.B.busy", 8'(busy), 8'h01);
        drive(1'b1, 8'hC3, 2'd2, 1'b1, 1'b0);
        tick();
        expect_beat("t1.C", 4'b0100, 8'hC3, 1'b1);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        check("t1.drain.valid", 8'(out_valid), 8'h00);
        check("t1.drain.busy",  8'(busy),      8'h00);

        // Channel 1 packet stalled by out_ready[1]=0 for four cycles
        out_ready = 4'b1101;
        drive(1'b1, 8'hD1, 2'd1, 1'b0, 1'b0);
        tick();
        expect_beat("t2.D1", 4'b0010, 8'hD1, 1'b0);
        drive(1'b1, 8'hD2, 2'd1, 1'b1, 1'b0);
        #1;
        check("t2.stall.in_ready", 8'(in_ready), 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_beat("t2.hold", 4'b0010, 8'hD1, 1'b0);
            check("t2.hold.in_ready", 8'(in_ready), 8'h00);
        end
        out_ready = 4'b1111;
        #1;
        check("t2.release.in_ready", 8'(in_ready), 8'h01);
        tick();
        expect_beat("t2.D2", 4'b0010, 8'hD2, 1'b1);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        check("t2.drain.valid", 8'(out_valid), 8'h00);

        // Dest changes mid-packet (and mode toggles); lock holds channel 2
        drive(1'b1, 8'hE1, 2'd2, 1'b0, 1'b0);
        tick();
        expect_beat("t4.E1", 4'b0100, 8'hE1, 1'b0);
        drive(1'b1, 8'hE2, 2'd0, 1'b0, 1'b1);
        tick();
        expect_beat("t4.E2", 4'b0100, 8'hE2, 1'b0);
        drive(1'b1, 8'hE3, 2'd0, 1'b1, 1'b0);
        tick();
        expect_beat("t4.E3", 4'b0100, 8'hE3, 1'b1);
        drive(1'b1, 8'hF1, 2'd0, 1'b1, 1'b0);
        tick();
        expect_beat("t4.F1", 4'b0001, 8'hF1, 1'b1);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        check("t4.drain.valid", 8'(out_valid), 8'h00);

        // Reset mid-packet with the slot full
        out_ready = 4'b0000;
        drive(1'b1, 8'h61, 2'd3, 1'b0, 1'b0);
        tick();
        expect_beat("t5.G1", 4'b1000, 8'h61, 1'b0);
        check("t5.G1.busy", 8'(busy), 8'h01);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.rst.valid",    8'(out_valid), 8'h00);
        check("t5.rst.busy",     8'(busy),      8'h00);
        check("t5.rst.last",     8'(out_last),  8'h00);
        check("t5.rst.in_ready", 8'(in_ready),  8'h01);
        #2;
        rst_n = 1'b1;

        // Round-robin single-beat packets from rr_ptr=0: channels 0,1,2,3,0
        out_ready = 4'b1111;
        drive(1'b1, 8'h70, 2'd3, 1'b1, 1'b1);
        tick();
        expect_beat("t3.p0", 4'b0001, 8'h70, 1'b1);
        check("t3.p0.busy", 8'(busy), 8'h00);
        drive(1'b1, 8'h71, 2'd3, 1'b1, 1'b1);
        tick();
        expect_beat("t3.p1", 4'b0010, 8'h71, 1'b1);
        drive(1'b1, 8'h72, 2'd3, 1'b1, 1'b1);
        tick();
        expect_beat("t3.p2", 4'b0100, 8'h72, 1'b1);
        drive(1'b1, 8'h73, 2'd0, 1'b1, 1'b1);
        tick();
        expect_beat("t3.p3", 4'b1000, 8'h73, 1'b1);
        drive(1'b1, 8'h74, 2'd2, 1'b1, 1'b1);
        tick();
        expect_beat("t3.p4.wrap", 4'b0001, 8'h74, 1'b1);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        check("t3.drain.valid", 8'(out_valid), 8'h00);

        // Back-to-back packets dest 0 then dest 3, no bubble
        drive(1'b1, 8'h80, 2'd0, 1'b0, 1'b0);
        tick();
        expect_beat("t6.J0", 4'b0001, 8'h80, 1'b0);
        drive(1'b1, 8'h81, 2'd0, 1'b1, 1'b0);
        tick();
        expect_beat("t6.J1", 4'b0001, 8'h81, 1'b1);
        drive(1'b1, 8'h90, 2'd3, 1'b0, 1'b0);
        #1;
        check("t6.switch.in_ready", 8'(in_ready), 8'h01);
        tick();
        expect_beat("t6.K0", 4'b1000, 8'h90, 1'b0);
        check("t6.K0.busy", 8'(busy), 8'h01);
        drive(1'b1, 8'h91, 2'd0, 1'b1, 1'b0);
        tick();
        expect_beat("t6.K1", 4'b1000, 8'h91, 1'b1);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        check("t6.drain.valid", 8'(out_valid), 8'h00);
        check("t6.drain.busy",  8'(busy),      8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
